hash_round_sequencer: RTL and testbench



---
 rtl/hash_round_sequencer_if.sv | 43 ++++
 rtl/hash_round_sequencer.sv | 166 ++++++++++++++++
 tb/tb_hash_round_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/hash_round_sequencer_if.sv
// Round-sequencer signal bundle: user start/done side, round-controller
// handshake, and the datapath load/update strobes.
// master: the sequencer. slave: whoever drives start/done_rnd and observes the rest.
interface hash_round_sequencer_if #(
  parameter int RIDX_W = 3
);
  logic              start;
  logic              done_rnd;
  logic              start_rnd;
  logic              ld_msg;
  logic              ld_state;
  logic              upd_state;
  logic [RIDX_W-1:0] round_idx;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start,
    input  done_rnd,
    output start_rnd,
    output ld_msg,
    output ld_state,
    output upd_state,
    output round_idx,
    output busy,
    output done,
    output err
  );

  modport slave (
    output start,
    output done_rnd,
    input  start_rnd,
    input  ld_msg,
    input  ld_state,
    input  upd_state,
    input  round_idx,
    input  busy,
    input  done,
    input  err
  );
endinterface

// File: rtl/hash_round_sequencer.sv
// Hash round sequencer: per request, loads the datapath, then runs NUM_ROUNDS
// start_rnd/done_rnd handshakes with the round controller, folding each
// result into the hash state, and finally pulses done.
// Optional build macro TIMEOUT_EN adds a per-round watchdog that aborts to
// IDLE with a one-cycle err pulse after TIMEOUT_CYC wait cycles.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  S_IDLE    | waiting for start; round index held at 0
//  S_LOAD    | ld_msg/ld_state strobe, one cycle
//  S_FIRE    | start_rnd pulse for the current round
//  S_WAIT_LO | waiting for done_rnd to drop (controller left idle)
//  S_WAIT_HI | waiting for done_rnd to return high (round finished)
//  S_UPDATE  | upd_state strobe; next round or finish
//  S_FIN     | done pulse, one cycle
module hash_round_sequencer #(
  parameter int NUM_ROUNDS  = 4,
  parameter int RIDX_W      = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input logic                    i_clk,
  input logic                    i_rst,
  hash_round_sequencer_if.master io_seq
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FIRE    = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4,
    S_UPDATE  = 3'd5,
    S_FIN     = 3'd6
  } state_t;

  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [RIDX_W-1:0] r_round_idx;
  logic              r_err;
  logic              w_timeout;

  logic w_start_rnd;
  logic w_ld_msg;
  logic w_upd_state;
  logic w_busy;
  logic w_done;

`ifdef TIMEOUT_EN
  // Wait-cycle counter: cleared in FIRE (always the entry to WAIT_LO), counts
  // every WAIT_LO/WAIT_HI cycle and saturates. The abort is taken on the wait
  // cycle whose increment would reach TIMEOUT_CYC, so a round gets exactly
  // TIMEOUT_CYC wait cycles before err.
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_waiting;

  assign w_waiting = (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
  assign w_timeout = w_waiting && (r_wait_cnt >= CNT_LAST);

  // Watchdog counter, saturating at TIMEOUT_CYC.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_FIRE) begin
      r_wait_cnt <= '0;
    end else if (w_waiting && (r_wait_cnt != CNT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Round index: zero whenever heading to IDLE, bumped only on UPDATE->FIRE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_round_idx <= '0;
    end else if (w_next == S_IDLE) begin
      r_round_idx <= '0;
    end else if ((r_state == S_UPDATE) && (w_next == S_FIRE)) begin
      r_round_idx <= r_round_idx + 1'b1;
    end
  end

  // err is shown during the IDLE cycle that follows a watchdog abort.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_timeout;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next      = r_state;
    w_start_rnd = 1'b0;
    w_ld_msg    = 1'b0;
    w_upd_state = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (io_seq.start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_ld_msg = 1'b1;
        w_busy   = 1'b1;
        w_next   = S_FIRE;
      end
      S_FIRE: begin
        w_start_rnd = 1'b1;
        w_busy      = 1'b1;
        w_next      = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        w_busy = 1'b1;
        if (w_timeout)             w_next = S_IDLE;
        else if (!io_seq.done_rnd) w_next = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        w_busy = 1'b1;
        if (w_timeout)            w_next = S_IDLE;
        else if (io_seq.done_rnd) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        w_upd_state = 1'b1;
        w_busy      = 1'b1;
        if (r_round_idx == LAST_IDX) w_next = S_FIN;
        else                         w_next = S_FIRE;
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign io_seq.start_rnd = w_start_rnd;
  assign io_seq.ld_msg    = w_ld_msg;
  assign io_seq.ld_state  = w_ld_msg;
  assign io_seq.upd_state = w_upd_state;
  assign io_seq.busy      = w_busy;
  assign io_seq.done      = w_done;
  assign io_seq.err       = r_err;
  assign io_seq.round_idx = r_round_idx;

endmodule

// File: tb/tb_hash_round_sequencer.sv
// Bench for hash_round_sequencer. Each request is described as a timeline of
// expected cycles (load, per-round fire/wait/update, fin) built from chosen
// responder wait lengths; every cycle's outputs are compared to that timeline.
module tb_hash_round_sequencer;
  localparam int NUM_ROUNDS  = 4;
  localparam int RIDX_W      = 3;
  localparam int TIMEOUT_CYC = 10;
  localparam int VW          = RIDX_W + 7;

  typedef logic [VW-1:0] vec_t;

  logic clk;
  logic rst;

  hash_round_sequencer_if #(.RIDX_W(RIDX_W)) bus ();

  hash_round_sequencer #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .RIDX_W     (RIDX_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_seq(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_no = 0;
  int n_srnd, n_upd, n_done;
  int last_done = -1;
  int prev_done = -1;

  int h_arr[NUM_ROUNDS];
  int l_arr[NUM_ROUNDS];

  // Expected output vector: {ld_msg, ld_state, start_rnd, upd_state, done, busy, err, round_idx}
  function automatic vec_t ev(input logic ld, input logic sr, input logic up,
                              input logic dn, input logic bz, input logic er,
                              input int idx);
    logic [RIDX_W-1:0] ri;
    ri = RIDX_W'(idx);
    return {ld, ld, sr, up, dn, bz, er, ri};
  endfunction

  function automatic logic st_val(input int mode, input int k);
    case (mode)
      1:       return 1'($urandom_range(0, 1));
      2:       return 1'b1;
      3:       return (k == 2);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs (done_rnd briefly at the wrong level to show
  // only the sampled level matters), compare outputs at the falling edge.
  task automatic cyc(input string tag, input vec_t exp, input logic st,
                     input logic dr, input logic rs);
    vec_t obs;
    bus.start    = st;
    rst          = rs;
    bus.done_rnd = ~dr;
    #2;
    bus.done_rnd = dr;
    @(negedge clk);
    obs = {bus.ld_msg, bus.ld_state, bus.start_rnd, bus.upd_state,
           bus.done, bus.busy, bus.err, bus.round_idx};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc_no, obs, exp);
    end
    if (bus.start_rnd) n_srnd++;
    if (bus.upd_state) n_upd++;
    if (bus.done) begin
      prev_done = last_done;
      last_done = cyc_no;
    end
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  // One request from an IDLE cycle with start=1. abort_rnd/to_rnd >= 0 select
  // a reset in that round's first WAIT_HI cycle or a stuck-low responder.
  task automatic run_req(input int mode, input int abort_rnd, input int to_rnd);
    n_srnd = 0;
    n_upd  = 0;
    n_done = 0;
    cyc("idle_start", ev(0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, 1'b0);
    cyc("load", ev(1, 0, 0, 0, 1, 0, 0), st_val(mode, -1), 1'b1, 1'b0);
    for (int k = 0; k < NUM_ROUNDS; k++) begin
      cyc("fire", ev(0, 1, 0, 0, 1, 0, k), st_val(mode, k), 1'b1, 1'b0);
      if (k == to_rnd) begin
        for (int j = 0; j < TIMEOUT_CYC; j++)
          cyc("wait_stuck", ev(0, 0, 0, 0, 1, 0, k), 1'b0, 1'b0, 1'b0);
        cyc("err_pulse", ev(0, 0, 0, 0, 0, 1, 0), 1'b0, 1'b1, 1'b0);
        cyc("after_err", ev(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0);
        chk_int("timeout_no_done", n_done + ((last_done >= 0 && last_done > cyc_no - TIMEOUT_CYC - 4) ? 1 : 0), 0);
        return;
      end
      for (int j = 0; j < h_arr[k]; j++)
        cyc("wait_lo_hold", ev(0, 0, 0, 0, 1, 0, k), st_val(mode, k), 1'b1, 1'b0);
      cyc("wait_lo_exit", ev(0, 0, 0, 0, 1, 0, k), st_val(mode, k), 1'b0, 1'b0);
      if (k == abort_rnd) begin
        cyc("abort_cycle", ev(0, 0, 0, 0, 1, 0, k), 1'b0, 1'b0, 1'b1);
        cyc("post_reset", ev(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0);
        chk_int("abort_upd_count", n_upd, k);
        return;
      end
      for (int j = 0; j < l_arr[k] - 1; j++)
        cyc("wait_hi_hold", ev(0, 0, 0, 0, 1, 0, k), st_val(mode, k), 1'b0, 1'b0);
      cyc("wait_hi_exit", ev(0, 0, 0, 0, 1, 0, k), st_val(mode, k), 1'b1, 1'b0);
      cyc("update", ev(0, 0, 1, 0, 1, 0, k), st_val(mode, k), 1'b1, 1'b0);
    end
    cyc("fin", ev(0, 0, 0, 1, 0, 0, NUM_ROUNDS - 1), st_val(mode, -1), 1'b1, 1'b0);
    if (last_done == cyc_no - 1) n_done = 1;
    chk_int("req_start_rnd_count", n_srnd, NUM_ROUNDS);
    chk_int("req_upd_count", n_upd, NUM_ROUNDS);
    chk_int("req_done_count", n_done, 1);
  endtask

  task automatic set_delays(input int h, input int l);
    for (int k = 0; k < NUM_ROUNDS; k++) begin
      h_arr[k] = h;
      l_arr[k] = l;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int d_first;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.done_rnd = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset_first_edge", ev(0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b1, 1'b1);
    cyc("reset_idle", ev(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0);
    cyc("idle_hold", ev(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0);

    // Nominal responder: done_rnd low 4 cycles after each start_rnd.
    set_delays(0, 4);
    run_req(0, -1, -1);
    cyc("idle_after_nominal", ev(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0);

    // Slow responder: done_rnd stays high 5 cycles before dropping.
    set_delays(5, 3);
    run_req(0, -1, -1);
    cyc("idle_after_slow", ev(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0);

    // start re-asserted throughout round 2 is ignored.
    set_delays(0, 4);
    run_req(3, -1, -1);
    cyc("idle_after_restart", ev(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0);

    // Reset in WAIT_HI of round 1, then a full request.
    last_done = -1;
    run_req(0, 1, -1);
    chk_int("abort_no_done", last_done, -1);
    run_req(0, -1, -1);
    cyc("idle_after_abort", ev(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0);

    // start held high, instant responder: back-to-back requests.
    set_delays(0, 1);
    run_req(2, -1, -1);
    d_first = last_done;
    run_req(2, -1, -1);
    chk_int("b2b_done_spacing", last_done - d_first, 2 + 4 * NUM_ROUNDS + 1);
    cyc("idle_after_b2b", ev(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0);

    // Random responder timings, random start noise, random idle gaps.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NUM_ROUNDS; k++) begin
        h_arr[k] = int'($urandom_range(0, 3));
        l_arr[k] = int'($urandom_range(1, 4));
      end
      run_req(1, -1, -1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++)
        cyc("random_gap", ev(0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0);
    end

`ifdef TIMEOUT_EN
    // Responder stuck low after round 0 start: watchdog abort, no done.
    set_delays(0, 4);
    last_done = -1;
    run_req(0, -1, 0);
    chk_int("timeout_done_never", last_done, -1);
    set_delays(0, 2);
    run_req(0, -1, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
